// File: rtl/acc_pkg.sv
// acc_drain shared definitions: geometry, cooldown length, FSM state type.
// Imported by the interface, the saturating adder and the drain top.
package acc_pkg;

  localparam int LANES    = 16;
  localparam int ACC_W    = 24;
  localparam int ROWS     = 16;
  localparam int COOL_CYC = 32;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_START,
    ST_DRAIN,
    ST_COOL
  } state_t;

endpackage

// File: rtl/acc_drain_if.sv
// Psum-in / PPU-out bundle for acc_drain.
// master drives psum rows; slave (acc_drain) answers with ready and drain data.
interface acc_drain_if #(
  parameter int LANES = acc_pkg::LANES,
  parameter int ACC_W = acc_pkg::ACC_W
);

  logic                   i_psum_valid;
  logic                   i_psum_first;
  logic                   i_psum_last;
  logic [LANES*ACC_W-1:0] i_psum_data;
  logic                   o_psum_ready;
  logic                   o_ppu_start;
  logic [LANES*ACC_W-1:0] o_acc_data;
  logic                   o_busy;
  logic [1:0]             o_tile_cnt;

  modport master (
    output i_psum_valid,
    output i_psum_first,
    output i_psum_last,
    output i_psum_data,
    input  o_psum_ready,
    input  o_ppu_start,
    input  o_acc_data,
    input  o_busy,
    input  o_tile_cnt
  );

  modport slave (
    input  i_psum_valid,
    input  i_psum_first,
    input  i_psum_last,
    input  i_psum_data,
    output o_psum_ready,
    output o_ppu_start,
    output o_acc_data,
    output o_busy,
    output o_tile_cnt
  );

endinterface

// File: rtl/acc_sat_add.sv
// Single-lane signed add clamped to the ACC_W range.
// Ports: a, b (two's complement operands), y (saturated sum).
module acc_sat_add #(
  parameter int ACC_W = acc_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y
);

  logic [ACC_W:0] s;

  assign s = {a[ACC_W-1], a} + {b[ACC_W-1], b};

  // Overflow iff the sign-extended carry disagrees with the result sign.
  always_comb begin
    y = s[ACC_W-1:0];
    if (s[ACC_W] != s[ACC_W-1])
      y = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                   : {1'b0, {(ACC_W-1){1'b1}}};
  end

endmodule

// File: rtl/acc_drain.sv
// Accumulates K-pass psum rows into a ROWS-deep buffer, then drains it to the PPU.
// Ports: i_clk, i_rst (sync, active high), bus (psum in, PPU out, status).
module acc_drain #(
  parameter int LANES    = acc_pkg::LANES,
  parameter int ACC_W    = acc_pkg::ACC_W,
  parameter int ROWS     = acc_pkg::ROWS,
  parameter int COOL_CYC = acc_pkg::COOL_CYC
) (
  input  logic  i_clk,
  input  logic  i_rst,
  acc_drain_if.slave bus
);
  import acc_pkg::*;

  localparam int W  = LANES * ACC_W;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS > COOL_CYC ? ROWS : COOL_CYC);

  state_t          state_q;
  state_t          state_d;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            first_q;
  logic            last_q;
  logic [W-1:0]    buf_q [ROWS];
  logic [W-1:0]    sum_row;

  logic            accept;
  logic            row0;
  logic            first_eff;
  logic            last_eff;
  logic            pass_done;

  logic            ready_d;
  logic            start_d;
  logic            busy_d;
  logic [W-1:0]    data_d;
  logic [1:0]      tile_d;

  assign accept    = bus.i_psum_valid & bus.o_psum_ready;
  assign row0      = (row_q == '0);
  // Pass flags come live on row 0 and are latched for the rest of the pass.
  assign first_eff = row0 ? bus.i_psum_first : first_q;
  assign last_eff  = row0 ? bus.i_psum_last  : last_q;
  assign pass_done = accept & last_eff
                   & (row_q == RW'(ROWS - 1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_sat_add #(.ACC_W(ACC_W)) u_add (
      .a (buf_q[row_q][k*ACC_W +: ACC_W]),
      .b (bus.i_psum_data[k*ACC_W +: ACC_W]),
      .y (sum_row[k*ACC_W +: ACC_W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_ACCUM;
      cnt_q            <= '0;
      row_q            <= '0;
      first_q          <= 1'b0;
      last_q           <= 1'b0;
      bus.o_psum_ready <= 1'b0;
      bus.o_ppu_start  <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_acc_data   <= '0;
      bus.o_tile_cnt   <= '0;
      for (int r = 0; r < ROWS; r++)
        buf_q[r] <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bus.o_psum_ready <= ready_d;
      bus.o_ppu_start  <= start_d;
      bus.o_busy       <= busy_d;
      bus.o_acc_data   <= data_d;
      bus.o_tile_cnt   <= tile_d;
      if (accept) begin
        row_q        <= row_q + 1'b1;
        buf_q[row_q] <= first_eff ? bus.i_psum_data
                                  : sum_row;
        if (row0) begin
          first_q <= bus.i_psum_first;
          last_q  <= bus.i_psum_last;
        end
      end
    end
  end

  // cnt_q: drain row index in DRAIN, idle cycle index in COOL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ACCUM: if (pass_done) state_d = ST_START;
      ST_START: begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(ROWS - 1)) begin
          state_d = ST_COOL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COOL: begin
        if (cnt_q == CW'(COOL_CYC - 1)) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ready_d = (state_d == ST_ACCUM);
    start_d = (state_d == ST_START);
    busy_d  = (state_d != ST_ACCUM);
    data_d  = '0;
    if (state_d == ST_DRAIN)
      data_d = buf_q[cnt_d[RW-1:0]];
    tile_d  = bus.o_tile_cnt;
    if (state_q == ST_DRAIN && state_d == ST_COOL)
      tile_d = bus.o_tile_cnt + 2'd1;
  end

endmodule
